// File: rtl/truth_table_sweeper_if.sv
// Control and block-under-test bundle for truth_table_sweeper.
// master = controller / bench side, slave = the sweeper itself.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int NV = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic            dut_y;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic [NV-1:0]   result;
    logic [N_IN:0]   mismatch_count;
    logic [N_IN-1:0] first_fail_idx;
    logic            pass;

    modport master (
        output start,
        output abort,
        output dut_y,
        input  vec_out,
        input  busy,
        input  done,
        input  result,
        input  mismatch_count,
        input  first_fail_idx,
        input  pass
    );

    modport slave (
        input  start,
        input  abort,
        input  dut_y,
        output vec_out,
        output busy,
        output done,
        output result,
        output mismatch_count,
        output first_fail_idx,
        output pass
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper for an N_IN-input combinational block,
// capturing its truth table and scoring it against EXP_MASK.
module truth_table_sweeper #(
    parameter int                    N_IN     = 4,
    parameter int                    SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]  EXP_MASK = 'h00FA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);
    localparam int NV = 2 ** N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NV-1:0]   res_q, res_d;
    logic [N_IN:0]   mc_q, mc_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            mc_q    <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            mc_q    <= mc_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // vec_q doubles as the vector index; it is all-ones on the last vector.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        mc_d    = mc_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    res_d   = '0;
                    mc_d    = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    res_d[vec_q] = bus.dut_y;
                    if (bus.dut_y != EXP_MASK[vec_q]) begin
                        mc_d = mc_q + (N_IN+1)'(1);
                        if (mc_q == '0) begin
                            ff_d = vec_q;
                        end
                    end
                    if (&vec_q) begin
                        done_d  = 1'b1;
                        pass_d  = (mc_d == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                vec_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.result         = res_q;
    assign bus.mismatch_count = mc_q;
    assign bus.first_fail_idx = ff_q;
    assign bus.pass           = pass_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: golden, stuck-at, held start,
// abort, mid-sweep reset and a SETTLE=3 build.
module tb_truth_table_sweeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    int         checks = 0;
    int         failures = 0;

    truth_table_sweeper_if #(.N_IN(4)) bus ();
    truth_table_sweeper_if #(.N_IN(4)) bus3 ();

    truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXP_MASK(16'h00FA)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3), .EXP_MASK(16'h00FA)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Y = !A & (B | D), {A,B,C,D} = v[3:0]
    function automatic logic golden(input logic [3:0] v);
        return !v[3] & (v[2] | v[0]);
    endfunction

    assign bus.dut_y  = (mode == 2'd0) ? golden(bus.vec_out) : (mode == 2'd2);
    assign bus3.dut_y = golden(bus3.vec_out);

    // Start accepted at the posedge between the two negedges (edge T);
    // returns at the negedge inside cycle T+1.
    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b pass=%b exp=0,0,0",
                     bus.busy, bus.done, bus.pass);
        end
        checks++;
        if (bus.vec_out !== 4'd0 || bus.result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data vec=%h result=%h exp=0,0000",
                     bus.vec_out, bus.result);
        end
        checks++;
        if (bus.mismatch_count !== 5'd0 || bus.first_fail_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_score mc=%0d ff=%0d exp=0,0",
                     bus.mismatch_count, bus.first_fail_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        int done_at = -1;
        int ndone = 0;
        mode = 2'd0;
        kick();
        for (int n = 1; n <= 36; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= 32) begin
                checks++;
                if (bus.vec_out !== 4'((n - 1) / 2)) begin
                    failures++;
                    $display("FAIL golden_vec cycle=T+%0d got=%0d exp=%0d",
                             n, bus.vec_out, (n - 1) / 2);
                end
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (n == 33 || n == 34) begin
                checks++;
                if (bus.busy !== (n == 33)) begin
                    failures++;
                    $display("FAIL golden_busy cycle=T+%0d got=%b exp=%b",
                             n, bus.busy, n == 33);
                end
            end
        end
        checks++;
        if (done_at != 33 || ndone != 1) begin
            failures++;
            $display("FAIL golden_done at=T+%0d pulses=%0d exp=T+33,1", done_at, ndone);
        end
        checks++;
        if (bus.result !== 16'h00FA || bus.mismatch_count !== 5'd0 ||
            bus.first_fail_idx !== 4'd0 || bus.pass !== 1'b1) begin
            failures++;
            $display("FAIL golden_score result=%h mc=%0d ff=%0d pass=%b exp=00fa,0,0,1",
                     bus.result, bus.mismatch_count, bus.first_fail_idx, bus.pass);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== 16'h00FA || bus.pass !== 1'b1) begin
            failures++;
            $display("FAIL idle_start_abort busy=%b result=%h pass=%b exp=0,00fa,1",
                     bus.busy, bus.result, bus.pass);
        end
    endtask

    task automatic test_stuck(input logic [1:0] m, input logic [15:0] eres,
                              input logic [4:0] emc, input logic [3:0] eff);
        int done_at = -1;
        mode = m;
        kick();
        for (int n = 1; n <= 36; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.done === 1'b1 && done_at < 0) done_at = n;
        end
        checks++;
        if (done_at != 33) begin
            failures++;
            $display("FAIL stuck%0d_done at=T+%0d exp=T+33", m, done_at);
        end
        checks++;
        if (bus.result !== eres || bus.mismatch_count !== emc ||
            bus.first_fail_idx !== eff || bus.pass !== 1'b0) begin
            failures++;
            $display("FAIL stuck%0d_score result=%h mc=%0d ff=%0d pass=%b exp=%h,%0d,%0d,0",
                     m, bus.result, bus.mismatch_count, bus.first_fail_idx,
                     bus.pass, eres, emc, eff);
        end
    endtask

    // A held start is ignored through DONE, then re-accepted in the
    // first IDLE cycle (T+34), so busy is low only in cycle T+34.
    task automatic test_start_held();
        int done_at = -1;
        int ndone = 0;
        mode = 2'd0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (n == 34 || n == 35) begin
                checks++;
                if (bus.busy !== (n == 35)) begin
                    failures++;
                    $display("FAIL held_busy cycle=T+%0d got=%b exp=%b",
                             n, bus.busy, n == 35);
                end
            end
        end
        checks++;
        if (done_at != 33 || ndone != 1) begin
            failures++;
            $display("FAIL held_done at=T+%0d pulses=%0d exp=T+33,1", done_at, ndone);
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.vec_out !== 4'd0) begin
            failures++;
            $display("FAIL held_abort busy=%b vec=%0d exp=0,0", bus.busy, bus.vec_out);
        end
    endtask

    task automatic test_abort_mid();
        int ndone = 0;
        mode = 2'd0;
        kick();
        for (int n = 2; n <= 11; n++) @(negedge clk);
        checks++;
        if (bus.vec_out !== 4'd5) begin
            failures++;
            $display("FAIL abort_pre_vec got=%0d exp=5", bus.vec_out);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
            bus.vec_out !== 4'd0) begin
            failures++;
            $display("FAIL abort_flags busy=%b done=%b pass=%b vec=%0d exp=0,0,0,0",
                     bus.busy, bus.done, bus.pass, bus.vec_out);
        end
        checks++;
        if (bus.result !== 16'h001A || bus.mismatch_count !== 5'd0 ||
            bus.first_fail_idx !== 4'd0) begin
            failures++;
            $display("FAIL abort_partial result=%h mc=%0d ff=%0d exp=001a,0,0",
                     bus.result, bus.mismatch_count, bus.first_fail_idx);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort_quiet active_cycles=%0d exp=0", ndone);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0;
        kick();
        for (int n = 2; n <= 19; n++) @(negedge clk);
        checks++;
        if (bus.vec_out !== 4'd9 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre vec=%0d busy=%b exp=9,1", bus.vec_out, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.vec_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.pass !== 1'b0 || bus.result !== 16'h0000 ||
            bus.mismatch_count !== 5'd0 || bus.first_fail_idx !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_clear vec=%0d busy=%b done=%b pass=%b result=%h mc=%0d ff=%0d exp=all 0",
                     bus.vec_out, bus.busy, bus.done, bus.pass, bus.result,
                     bus.mismatch_count, bus.first_fail_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_settle3();
        int done_at = -1;
        @(negedge clk);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 4 || n == 5) begin
                checks++;
                if (bus3.vec_out !== 4'(n / 5)) begin
                    failures++;
                    $display("FAIL s3_vec cycle=T+%0d got=%0d exp=%0d",
                             n, bus3.vec_out, n / 5);
                end
            end
            if (bus3.done === 1'b1 && done_at < 0) done_at = n;
        end
        checks++;
        if (done_at != 65) begin
            failures++;
            $display("FAIL s3_done at=T+%0d exp=T+65", done_at);
        end
        checks++;
        if (bus3.result !== 16'h00FA || bus3.pass !== 1'b1 ||
            bus3.mismatch_count !== 5'd0) begin
            failures++;
            $display("FAIL s3_score result=%h pass=%b mc=%0d exp=00fa,1,0",
                     bus3.result, bus3.pass, bus3.mismatch_count);
        end
    endtask

    initial begin
        mode       = 2'd0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        test_reset();
        test_golden();
        test_start_abort_idle();
        test_stuck(2'd1, 16'h0000, 5'd6, 4'd1);
        test_stuck(2'd2, 16'hFFFF, 5'd10, 4'd0);
        test_start_held();
        test_abort_mid();
        test_reset_mid();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
